multicycle_ctrl_fsm: RTL
========================

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles a memory state waits for mem_ready; 0 = no timeout.
REQ-002 SHALL have parameter CNT_W, default 32, width of wait and performance counters.
REQ-003 SHALL use: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 opcode  input  7  instruction bits [6:0] from IR.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write  output  1 each  datapath strobes.
REQ-009 pc_source  output  2  00 ALU result, 01 ALUOut, 10 ALU result with bit0 cleared.
REQ-010 alu_src_a  output  2  00 PC, 01 reg A, 10 old PC.
REQ-011 alu_src_b  output  2  00 reg B, 01 constant 4, 10 immediate.
REQ-012 alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
REQ-013 reg_src  output  2  00 ALUOut, 01 MDR, 10 PC (link).
REQ-014 is_ecall  output  1  halt reached; trap  output  1  fault; trap_cause  output  2  01 illegal opcode, 10 memory timeout.
REQ-015 cycle_cnt, instret_cnt  output  CNT_W each  performance counters.

Function
REQ-016 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, HALT, TRAP; strobes are Moore-decoded from state, qualified by mem_ready only where stated; all unlisted outputs are 0.
REQ-017 FETCH: mem_read=1, alu_src_b=01; ir_write and pc_write asserted only in the cycle mem_ready=1; stays in FETCH until mem_ready=1, then -> DECODE.
REQ-018 DECODE: alu_src_a=10, alu_src_b=10 (ALUOut = branch/JAL target); next state by opcode: LOAD/STORE->MEM_ADDR, OP->EXEC_R, OP-IMM->EXEC_I, BRANCH->BRANCH, JAL->JAL, JALR->JALR, SYSTEM->HALT, any other->TRAP with trap_cause=01.
REQ-019 MEM_ADDR: alu_src_a=01, alu_src_b=10; LOAD->MEM_RD, STORE->MEM_WR.
REQ-020 MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready, then -> MEM_WB. MEM_WB: reg_write=1, reg_src=01 -> FETCH.
REQ-021 MEM_WR: mem_write=1, i_or_d=1; holds until mem_ready, then -> FETCH.
REQ-022 EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> ALU_WB. EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=11 -> ALU_WB. ALU_WB: reg_write=1, reg_src=00 -> FETCH.
REQ-023 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-024 JAL: pc_write=1, pc_source=01, reg_write=1, reg_src=10 -> FETCH.
REQ-025 JALR: alu_src_a=01, alu_src_b=10, alu_op=00, pc_write=1, pc_source=10, reg_write=1, reg_src=10 -> FETCH.
REQ-026 HALT: is_ecall=1, sticky until reset; no strobes.
REQ-027 TRAP: trap=1, trap_cause held, sticky until reset; no strobes.
REQ-028 Wait counter clears on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready=0; when MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT-1 with mem_ready=0 -> TRAP, trap_cause=10.
REQ-029 mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Reset
REQ-030 reset at any edge, including mid-access, forces FETCH, clears wait counter, trap, trap_cause, and both performance counters; reset has priority over every transition.
REQ-031 After reset, outputs equal FETCH decode (mem_read=1, alu_src_b=01, all else 0).

Configuration
REQ-032 With CTRL_PERF_CNT_EN defined: cycle_cnt increments every non-reset cycle while not in HALT/TRAP; instret_cnt increments on each transition into FETCH from a completing state; both wrap at 2^CNT_W.
REQ-033 Without CTRL_PERF_CNT_EN: both counters constant 0, no counter flops.

Structure
REQ-034 Shared package holds opcode constants, state enum, and pc_source/alu_src/alu_op/reg_src/trap_cause encodings.
REQ-035 Performance counters SHALL be sub-module ctrl_perf_cnt; FSM stays in multicycle_ctrl_fsm.

Verification
REQ-036 ADD (0x33), mem_ready always 1 -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 in cycle 4; instret_cnt=1.
REQ-037 LOAD (0x03), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with reg_src=01.
REQ-038 JALR (0x67) -> JALR state shows pc_write=1, pc_source=10, reg_write=1, reg_src=10 same cycle.
REQ-039 Opcode 0x7F -> TRAP, trap_cause=01, held 20 cycles; MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP with trap_cause=10 after 4 cycles.
REQ-040 ECALL (0x73) -> HALT, is_ecall=1 sticky; reset asserted mid-MEM_WR -> FETCH next edge, counters 0.
REQ-041 Build without CTRL_PERF_CNT_EN, 10 instructions -> cycle_cnt=instret_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcode constants, state encoding and datapath select encodings
// for the multicycle control FSM.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR, ST_EXEC_R,
    ST_EXEC_I, ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR, ST_HALT, ST_TRAP
  } state_e;

  localparam logic [1:0] PCSRC_ALU       = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_ALU_ALIGN = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_REG_A  = 2'b01;
  localparam logic [1:0] SRCA_OLD_PC = 2'b10;

  localparam logic [1:0] SRCB_REG_B = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] REGSRC_ALUOUT = 2'b00;
  localparam logic [1:0] REGSRC_MDR    = 2'b01;
  localparam logic [1:0] REGSRC_PC     = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Datapath control bundle decoded from the current state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_src;
    logic       is_ecall;
    logic       trap;
    logic [1:0] trap_cause;
  } ctrl_t;

  function automatic logic is_mem_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_perf_cnt.sv
// Cycle and retired-instruction counters; present only when CTRL_PERF_CNT_EN
// is defined, otherwise both outputs are tied to zero with no flops.
module ctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cycle_en,
  input  logic             i_instret,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // Both counters wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (i_cycle_en) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (i_instret)  r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  logic w_unused;
  assign w_unused      = &{1'b0, clk, reset, i_cycle_en, i_instret};
  assign o_cycle_cnt   = '0;
  assign o_instret_cnt = '0;
`endif

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V style control unit: Moore-decoded datapath strobes with a
// memory wait timeout. Define CTRL_PERF_CNT_EN to enable the performance counters.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_src,
  output logic             is_ecall,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  state_e           r_state;
  state_e           w_state_next;
  logic [1:0]       r_trap_cause;
  logic [1:0]       w_trap_cause_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;
  ctrl_t            w_ctrl;

  assign w_timeout = (MEM_TIMEOUT != 0) && is_mem_state(r_state) && !mem_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_trap_cause <= TRAP_NONE;
    end else begin
      r_state      <= w_state_next;
      r_trap_cause <= w_trap_cause_next;
    end
  end

  // Memory wait counter restarts on every state entry
  always_ff @(posedge clk) begin
    if (reset || (w_state_next != r_state)) begin
      r_wait_cnt <= '0;
    end else if (is_mem_state(r_state) && !mem_ready) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_trap_cause_next = r_trap_cause;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) begin
          w_state_next = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: w_state_next = ST_MEM_ADDR;
          OPC_OP:              w_state_next = ST_EXEC_R;
          OPC_OP_IMM:          w_state_next = ST_EXEC_I;
          OPC_BRANCH:          w_state_next = ST_BRANCH;
          OPC_JAL:             w_state_next = ST_JAL;
          OPC_JALR:            w_state_next = ST_JALR;
          OPC_SYSTEM:          w_state_next = ST_HALT;
          default: begin
            w_state_next      = ST_TRAP;
            w_trap_cause_next = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADDR: w_state_next = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD, ST_MEM_WR: begin
        if (mem_ready) begin
          w_state_next = (r_state == ST_MEM_RD) ? ST_MEM_WB : ST_FETCH;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = TRAP_TIMEOUT;
        end
      end
      ST_EXEC_R, ST_EXEC_I: w_state_next = ST_ALU_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR: w_state_next = ST_FETCH;
      ST_HALT, ST_TRAP: w_state_next = r_state;
      default: w_state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.alu_src_a = SRCA_PC;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLD_PC;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = SRCA_REG_A;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_src   = REGSRC_MDR;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        w_ctrl.alu_src_a = SRCA_REG_A;
        w_ctrl.alu_src_b = SRCB_REG_B;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_src_a = SRCA_REG_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ITYPE;
      end
      ST_ALU_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_src   = REGSRC_ALUOUT;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = SRCA_REG_A;
        w_ctrl.alu_src_b     = SRCB_REG_B;
        w_ctrl.alu_op        = ALUOP_BRANCH;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JAL: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_ALUOUT;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_src   = REGSRC_PC;
      end
      ST_JALR: begin
        w_ctrl.alu_src_a = SRCA_REG_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_ALU_ALIGN;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_src   = REGSRC_PC;
      end
      ST_HALT: w_ctrl.is_ecall = 1'b1;
      ST_TRAP: begin
        w_ctrl.trap       = 1'b1;
        w_ctrl.trap_cause = r_trap_cause;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign reg_write     = w_ctrl.reg_write;
  assign pc_source     = w_ctrl.pc_source;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign reg_src       = w_ctrl.reg_src;
  assign is_ecall      = w_ctrl.is_ecall;
  assign trap          = w_ctrl.trap;
  assign trap_cause    = w_ctrl.trap_cause;

  // Retirement is any return to FETCH from an instruction's final state
  logic w_cycle_en;
  logic w_instret;
  assign w_cycle_en = (r_state != ST_HALT) && (r_state != ST_TRAP);
  assign w_instret  = (w_state_next == ST_FETCH) && (r_state != ST_FETCH);

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_cycle_en   (w_cycle_en),
    .i_instret    (w_instret),
    .o_cycle_cnt  (cycle_cnt),
    .o_instret_cnt(instret_cnt)
  );

endmodule
